alu_seq: RTL



---
 rtl/alu_seq.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, multi-cycle successor to the 8-bit combinational ALU.
//
// Accepts one request at a time on a valid/ready handshake and reports the
// result with a one-cycle out_valid pulse. It keeps a persistent N/V/Z/C
// condition-code register. Shifts run one bit per cycle. MUL is an
// iterative shift-add that is only built when ALU_SEQ_MUL_EN is defined.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   : F=14 is an unsigned WIDTH x WIDTH multiply (latency 1+WIDTH).
//   undefined : F=14 returns Y=0 with flags unchanged (latency 1).
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   in_valid   request strobe; A/B/F are captured when in_valid & in_ready
//   in_ready   high only while idle
//   A, B       WIDTH-bit operands; B[SW-1:0] is the shift amount
//   F          4-bit opcode
//   Y          registered result; holds until the next completed op
//   out_valid  one-cycle pulse when Y and the flags are updated
//   N, V, Z, C registered condition codes
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       F,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  output logic             N,
  output logic             V,
  output logic             Z,
  output logic             C
);

  localparam int SW = $clog2(WIDTH);
  // The counter must reach WIDTH for MUL, so it is one bit wider than shamt.
  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LSL  = 4'd2;
  localparam logic [3:0] OP_LSR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_COM  = 4'd5;
  localparam logic [3:0] OP_NEG  = 4'd6;
  localparam logic [3:0] OP_CLR  = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SBC  = 4'd9;
  localparam logic [3:0] OP_AND  = 4'd10;
  localparam logic [3:0] OP_OR   = 4'd11;
  localparam logic [3:0] OP_ASR  = 4'd12;
  localparam logic [3:0] OP_CMP  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_PASS = 4'd15;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_MUL} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             n_q, n_d, v_q, v_d, z_q, z_d, c_q, c_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] sh_q, sh_d;   // shift operand; MUL multiplicand
  logic [CW-1:0]    cnt_q, cnt_d;

  // Single-cycle datapath, all at WIDTH+1 bits.
  logic             cin_a, cin_s;
  logic [WIDTH:0]   add_s, sub_s;
  logic             add_v, sub_v;
  logic [SW-1:0]    shamt;

  // Iterative shift step.
  logic [WIDTH-1:0] sh_nx;
  logic             sh_out;

  // Opcode-decode scratch.
  logic [WIDTH-1:0] res;
  logic             wr_y, wr_nz;

`ifdef ALU_SEQ_MUL_EN
  // {high, low} product; low half starts as the multiplier and drains out.
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_nx;
  logic [WIDTH:0]     madd;
`endif

  assign shamt = B[SW-1:0];
  assign cin_a = (F == OP_ADC) & c_q;
  assign cin_s = (F == OP_SBC) & c_q;
  assign add_s = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin_a};
  assign sub_s = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, cin_s};

  // Signed overflow = carry into MSB xor carry out of MSB. For subtraction
  // the borrow is the inverted carry, which cancels against the inverted B,
  // so both reduce to the same expression. Carry-in is included, so this is
  // the true overflow of the whole op.
  assign add_v = add_s[WIDTH] ^ A[WIDTH-1] ^ B[WIDTH-1] ^ add_s[WIDTH-1];
  assign sub_v = sub_s[WIDTH] ^ A[WIDTH-1] ^ B[WIDTH-1] ^ sub_s[WIDTH-1];

  always_comb begin
    sh_nx  = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
    sh_out = sh_q[0];
    if (op_q == OP_LSL) begin
      sh_nx  = {sh_q[WIDTH-2:0], 1'b0};
      sh_out = sh_q[WIDTH-1];
    end else if (op_q == OP_LSR) begin
      sh_nx  = {1'b0, sh_q[WIDTH-1:1]};
    end
  end

`ifdef ALU_SEQ_MUL_EN
  assign madd    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                   (prod_q[0] ? {1'b0, sh_q} : {(WIDTH+1){1'b0}});
  assign prod_nx = {madd, prod_q[WIDTH-1:1]};
`endif

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    n_d     = n_q;
    v_d     = v_q;
    z_d     = z_q;
    c_d     = c_q;
    op_d    = op_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    res     = '0;
    wr_y    = 1'b0;
    wr_nz   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    prod_d  = prod_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
          wr_y    = 1'b1;
          wr_nz   = 1'b1;
          op_d    = F;
          case (F)
            OP_ADD, OP_ADC: begin
              res = add_s[WIDTH-1:0];
              c_d = add_s[WIDTH];
              v_d = add_v;
            end
            OP_SUB, OP_SBC, OP_CMP: begin
              res = sub_s[WIDTH-1:0];
              c_d = sub_s[WIDTH];
              v_d = sub_v;
              if (F == OP_CMP) wr_y = 1'b0;
            end
            OP_LSL, OP_LSR, OP_ASR: begin
              res = A;
              v_d = 1'b0;
              // shamt=0 completes now with C untouched.
              if (shamt != '0) begin
                state_d = S_SHIFT;
                sh_d    = A;
                cnt_d   = {1'b0, shamt};
                wr_y    = 1'b0;
                wr_nz   = 1'b0;
                v_d     = v_q;
              end
            end
            OP_XOR: begin res = A ^ B; v_d = 1'b0; end
            OP_COM: begin res = ~A;    v_d = 1'b0; end
            OP_AND: begin res = A & B; v_d = 1'b0; end
            OP_OR:  begin res = A | B; v_d = 1'b0; end
            OP_NEG: begin
              res = '0 - A;
              v_d = (A == {1'b1, {(WIDTH-1){1'b0}}});
              c_d = |A;
            end
            OP_CLR: begin
              res = '0;
              v_d = 1'b0;
              c_d = 1'b0;
            end
            OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
              state_d = S_MUL;
              sh_d    = A;
              prod_d  = {{WIDTH{1'b0}}, B};
              cnt_d   = CW'(WIDTH);
              wr_y    = 1'b0;
              wr_nz   = 1'b0;
`else
              res   = '0;
              wr_nz = 1'b0;
`endif
            end
            default: begin res = A; v_d = 1'b0; end  // PASS
          endcase
        end
      end

      S_SHIFT: begin
        sh_d  = sh_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res     = sh_nx;
          wr_y    = 1'b1;
          wr_nz   = 1'b1;
          v_d     = 1'b0;
          c_d     = sh_out;
        end
      end

`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        prod_d = prod_nx;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res     = prod_nx[WIDTH-1:0];
          wr_y    = 1'b1;
          wr_nz   = 1'b1;
          c_d     = |prod_nx[2*WIDTH-1:WIDTH];
          v_d     = |prod_nx[2*WIDTH-1:WIDTH];
        end
      end
`endif

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_y) y_d = res;
    if (wr_nz) begin
      n_d = res[WIDTH-1];
      z_d = (res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      op_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
`ifdef ALU_SEQ_MUL_EN
      prod_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
      c_q     <= c_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
      prod_q  <= prod_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Y = y_q;
  assign N = n_q;
  assign V = v_q;
  assign Z = z_q;
  assign C = c_q;

endmodule
